// File: rtl/fp_cvt_pkg.sv
// -----------------------------------------------------------------------------
// fp_cvt_pkg
// Shared constants and helpers for the FP32->FP16 conversion arbiter slice.
//   FP32_W / FP16_W : operand and result widths
//   FP16_EXP_INF    : all-ones FP16 exponent (inf / NaN)
//   FP16_QNAN       : canonical positive quiet NaN
//   id_width()      : width of a requester index for n requesters (min 1)
// -----------------------------------------------------------------------------
package fp_cvt_pkg;

  localparam int          FP32_W       = 32;
  localparam int          FP16_W       = 16;
  localparam logic [4:0]  FP16_EXP_INF = 5'h1F;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  // A single requester still needs a 1-bit tag so ports never collapse to
  // zero width.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fp32_to_fp16.sv
// -----------------------------------------------------------------------------
// fp32_to_fp16
// Purely combinational FP32 -> FP16 converter (truncating).
//   a : FP32 operand
//   y : FP16 result
// NaN keeps sign and upper payload and is forced quiet; overflow gives +/-inf;
// FP32 denormals flush to +/-0; small results become FP16 denormals or zero.
// -----------------------------------------------------------------------------
module fp32_to_fp16
  import fp_cvt_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  output logic [FP16_W-1:0] y
);

  logic        sign;
  logic [7:0]  exp;
  logic [22:0] man;
  logic [4:0]  shamt;

  assign sign = a[31];
  assign exp  = a[30:23];
  assign man  = a[22:0];

  // Denormal path: the implicit-one significand is shifted right so that one
  // LSB of the result weighs 2^-24. exp 112 needs a shift of 14, exp 103 a
  // shift of 23; anything below exp 103 truncates to zero.
  assign shamt = 5'(8'd126 - exp);

  always_comb begin
    y = {sign, 15'h0000};
    if (exp == 8'hFF) begin
      if (man != 23'd0) begin
        y = FP16_QNAN | {sign, 5'h00, man[22:13]};
      end else begin
        y = {sign, FP16_EXP_INF, 10'h000};
      end
    end else if (exp == 8'h00) begin
      y = {sign, 15'h0000};
    end else if (exp >= 8'd143) begin
      // FP16 biased exponent would be 31 or more.
      y = {sign, FP16_EXP_INF, 10'h000};
    end else if (exp >= 8'd113) begin
      y = {sign, 5'(exp - 8'd112), man[22:13]};
    end else if (exp >= 8'd103) begin
      y = {sign, 5'h00, 10'({1'b1, man} >> shamt)};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over N requesters; owns the rotating priority pointer.
//   clk, rst  : clock, asynchronous active-high reset (ptr -> 0)
//   en        : grant permission for this cycle
//   req       : request vector
//   grant     : one-hot grant (zero when nothing granted)
//   grant_idx : index of the granted requester
//   advance   : a grant is issued this cycle (pointer moves past grant_idx)
// -----------------------------------------------------------------------------
module rr_arbiter
  import fp_cvt_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           advance
);

  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] ptr_next;
  int             scan_idx;

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    advance   = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        scan_idx = (int'(ptr_reg) + k) % N;
        if (!advance && req[scan_idx]) begin
          advance   = 1'b1;
          grant_idx = IDW'(scan_idx);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = advance && (grant_idx == IDW'(gi));
    end
  endgenerate

  always_comb begin
    ptr_next = ptr_reg;
    if (advance) begin
      ptr_next = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/fp16_cvt_arbiter.sv
// -----------------------------------------------------------------------------
// fp16_cvt_arbiter
// Shares one combinational FP32->FP16 converter among NUM_REQ valid/ready
// requesters. One operand is accepted per cycle (round robin) and its FP16
// result is returned one cycle later on a single tagged response stream.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : grant enable (an in-flight response still drains when low)
//   req_valid  : per-requester operand valid
//   req_data   : per-requester FP32 operand, requester i at [32*i+31:32*i]
//   req_ready  : per-requester accept, one-hot or zero
//   rsp_valid / rsp_data / rsp_id / rsp_ready : tagged FP16 response stream
// Optional (macro FP16_CVT_STATS_EN):
//   stat_conv  : saturating count of accepted operands
//   stat_ovf   : saturating count of finite operands that converted to +/-inf
// -----------------------------------------------------------------------------
module fp16_cvt_arbiter
  import fp_cvt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FP32_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [FP16_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  input  logic                      rsp_ready
`ifdef FP16_CVT_STATS_EN
  ,
  output logic [31:0]               stat_conv,
  output logic [31:0]               stat_ovf
`endif
);

  logic              rsp_valid_reg;
  logic [FP16_W-1:0] rsp_data_reg;
  logic [ID_W-1:0]   rsp_id_reg;

  logic              can_accept;
  logic              arb_en;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_fire;
  logic [FP32_W-1:0] cvt_in;
  logic [FP16_W-1:0] cvt_out;

  // Output slot is free when empty or being drained this same cycle.
  assign can_accept = en && (!rsp_valid_reg || rsp_ready);
  // Gating with rst keeps req_ready low for the whole reset pulse.
  assign arb_en     = can_accept && !rst;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .advance   (grant_fire)
  );

  assign cvt_in = req_data[grant_idx*FP32_W +: FP32_W];

  fp32_to_fp16 u_cvt (
    .a (cvt_in),
    .y (cvt_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
    end else if (grant_fire) begin
      rsp_valid_reg <= 1'b1;
      rsp_data_reg  <= cvt_out;
      rsp_id_reg    <= grant_idx;
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;

`ifdef FP16_CVT_STATS_EN
  logic        cvt_ovf;
  logic [31:0] stat_conv_reg;
  logic [31:0] stat_ovf_reg;

  // Only finite inputs count; an FP32 inf passing through is not an overflow.
  assign cvt_ovf = (cvt_in[30:23] != 8'hFF) &&
                   (cvt_out[14:0] == {FP16_EXP_INF, 10'h000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_conv_reg <= '0;
      stat_ovf_reg  <= '0;
    end else if (grant_fire) begin
      if (stat_conv_reg != 32'hFFFF_FFFF) begin
        stat_conv_reg <= stat_conv_reg + 32'd1;
      end
      if (cvt_ovf && (stat_ovf_reg != 32'hFFFF_FFFF)) begin
        stat_ovf_reg <= stat_ovf_reg + 32'd1;
      end
    end
  end

  assign stat_conv = stat_conv_reg;
  assign stat_ovf  = stat_ovf_reg;
`endif

endmodule

// File: tb/tb_fp16_cvt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp16_cvt_arbiter
// Self-checking bench for fp16_cvt_arbiter (NUM_REQ=4). Stats ports are
// exercised when FP16_CVT_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fp16_cvt_arbiter;

  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [NR-1:0]  req_valid;
  logic [NR*32-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           rsp_valid;
  logic [15:0]    rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ready;
`ifdef FP16_CVT_STATS_EN
  logic [31:0]    stat_conv;
  logic [31:0]    stat_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp16_cvt_arbiter #(.NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
`ifdef FP16_CVT_STATS_EN
    ,
    .stat_conv (stat_conv),
    .stat_ovf  (stat_ovf)
`endif
  );

  typedef struct {
    logic [31:0] in;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[32*i +: 32] = v;
  endtask

  function automatic real pow2(input int p);
    real r;
    r = 1.0;
    if (p >= 0) for (int i = 0; i < p; i++) r = r * 2.0;
    else for (int i = 0; i < -p; i++) r = r / 2.0;
    return r;
  endfunction

  // Reference conversion from the numeric value: classify, then place the
  // magnitude on the FP16 grid with truncation.
  function automatic logic [15:0] ref_cvt(input logic [31:0] x);
    logic       s;
    int         e;
    int         m;
    real        mag;
    int         ex;
    int         mant;
    logic [4:0] ex5;
    s = x[31];
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 255) begin
      if (m != 0) return {s, 5'h1F, 1'b1, x[21:13]};
      return {s, 15'h7C00};
    end
    if (e == 0) return {s, 15'h0000};
    mag = (1.0 + real'(m) / pow2(23)) * pow2(e - 127);
    if (mag >= 65536.0) return {s, 15'h7C00};
    if (mag >= pow2(-14)) begin
      ex = 15;
      while (mag < pow2(ex)) ex--;
      mant = $rtoi((mag / pow2(ex) - 1.0) * 1024.0);
      ex5  = 5'(ex + 15);
      return {s, ex5, 10'(mant)};
    end
    mant = $rtoi(mag * pow2(24));
    return {s, 5'h00, 10'(mant)};
  endfunction

  function automatic logic [31:0] rnd_operand();
    if ($urandom_range(0, 2) == 0) return $urandom;
    return {1'($urandom), 8'($urandom_range(98, 145)), 23'($urandom)};
  endfunction

  vec_t vecs[14];
  logic [31:0] fair_data[NR];

  // model state for the random phase
  int   m_ptr;
  bit   m_full;
  logic [15:0] m_data;
  int   m_id;
  int   last_g;
  int   g;
  int   m_conv;
  int   m_ovf;
  logic [15:0] rc;

  initial begin
    vecs[0]  = '{32'h3F800000, 16'h3C00};
    vecs[1]  = '{32'h47800000, 16'h7C00};
    vecs[2]  = '{32'h35800000, 16'h0010};
    vecs[3]  = '{32'h7F800001, 16'h7E00};
    vecs[4]  = '{32'h80000000, 16'h8000};
    vecs[5]  = '{32'hC0000000, 16'hC000};
    vecs[6]  = '{32'h7F800000, 16'h7C00};
    vecs[7]  = '{32'h00000001, 16'h0000};
    vecs[8]  = '{32'h477FE000, 16'h7BFF};
    vecs[9]  = '{32'h38800000, 16'h0400};
    vecs[10] = '{32'h33800000, 16'h0001};
    vecs[11] = '{32'h33000000, 16'h0000};
    vecs[12] = '{32'hFFFFFFFF, 16'hFFFF};
    vecs[13] = '{32'h3FFFFFFF, 16'h3FFF};
    for (int i = 0; i < NR; i++) fair_data[i] = 32'h3F800000 + (32'(i) << 23);

    // ---------------- reset ----------------
    rst       = 1'b1;
    en        = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_data  = '0;
    for (int i = 0; i < NR; i++) set_data(i, fair_data[i]);
    repeat (2) step();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // ---------------- fairness ----------------
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fair_ready", 32'(req_ready), 32'(1) << (k % NR));
      step();
      chk("fair_valid", 32'(rsp_valid), 32'd1);
      chk("fair_id", 32'(rsp_id), 32'(k % NR));
      chk("fair_data", 32'(rsp_data), 32'(ref_cvt(fair_data[k % NR])));
      $display("fair k=%0d id=%0d data=%h", k, rsp_id, rsp_data);
    end

    // ---------------- conversion table via requester 0 ----------------
    req_valid = 4'b0001;
    for (int i = 0; i < 14; i++) begin
      set_data(0, vecs[i].in);
      #1;
      chk("tbl_ready", 32'(req_ready), 32'd1);
      step();
      chk("tbl_valid", 32'(rsp_valid), 32'd1);
      chk("tbl_id", 32'(rsp_id), 32'd0);
      chk("tbl_data", 32'(rsp_data), 32'(vecs[i].exp));
      $display("cvt in=%h out=%h exp=%h", vecs[i].in, rsp_data, vecs[i].exp);
    end

    // ---------------- backpressure (ptr now 1) ----------------
    req_valid = '1;
    for (int i = 0; i < NR; i++) set_data(i, fair_data[i]);
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'b0010);
    step();
    chk("bp_first_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b0;
    #1;
    chk("bp_stall_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
      chk("bp_hold_data", 32'(rsp_data), 32'h4000);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      $display("stall cycle %0d id=%0d data=%h", k, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    step();
    chk("bp_release_id", 32'(rsp_id), 32'd2);
    chk("bp_release_data", 32'(rsp_data), 32'h4400);

    // ---------------- enable low ----------------
    en = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("en0_ready_a", 32'(req_ready), 32'd0);
    step();
    chk("en0_hold_valid", 32'(rsp_valid), 32'd1);
    chk("en0_hold_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b1;
    #1;
    chk("en0_ready_b", 32'(req_ready), 32'd0);
    step();
    chk("en0_drained", 32'(rsp_valid), 32'd0);
    chk("en0_ready_c", 32'(req_ready), 32'd0);
    step();
    chk("en0_still_empty", 32'(rsp_valid), 32'd0);
    en = 1'b1;
    #1;
    chk("en1_ready", 32'(req_ready), 32'b1000);
    step();
    chk("en1_id", 32'(rsp_id), 32'd3);
    chk("en1_data", 32'(rsp_data), 32'h4800);

    // ---------------- async reset while FULL ----------------
    rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_data", 32'(rsp_data), 32'd0);
    chk("rst_mid_id", 32'(rsp_id), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_ptr_zero", 32'(req_ready), 32'b0001);
    step();
    chk("rst_after_id", 32'(rsp_id), 32'd0);
    chk("rst_after_data", 32'(rsp_data), 32'h3C00);

    // ---------------- randomized against model ----------------
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    m_ptr = 0; m_full = 0; m_data = '0; m_id = 0; last_g = -1;
    m_conv = 0; m_ovf = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full) begin
        chk("rnd_rsp_data", 32'(rsp_data), 32'(m_data));
        chk("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
      end
      if (last_g >= 0) req_valid[last_g] = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          req_valid[i] = 1'b1;
          set_data(i, rnd_operand());
        end
      end
      #1;
      g = -1;
      if (en && (!m_full || rsp_ready)) begin
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        end
      end
      chk("rnd_req_ready", 32'(req_ready), (g >= 0) ? (32'(1) << g) : 32'd0);
      @(posedge clk);
      if (g >= 0) begin
        rc = ref_cvt(req_data[32*g +: 32]);
        m_full = 1'b1;
        m_data = rc;
        m_id   = g;
        m_ptr  = (g + 1) % NR;
        m_conv++;
        if (req_data[32*g+30 -: 8] != 8'hFF && rc[14:0] == 15'h7C00) m_ovf++;
        $display("rnd cyc=%0d grant=%0d in=%h exp_out=%h", cyc, g, req_data[32*g +: 32], rc);
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
      last_g = g;
      #1;
    end

`ifdef FP16_CVT_STATS_EN
    chk("rnd_stat_conv", stat_conv, 32'(m_conv));
    chk("rnd_stat_ovf", stat_ovf, 32'(m_ovf));
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    chk("stat_reset_conv", stat_conv, 32'd0);
    chk("stat_reset_ovf", stat_ovf, 32'd0);
    en = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    set_data(0, 32'h3F800000); step();
    set_data(0, 32'h40000000); step();
    set_data(0, 32'hC1200000); step();
    set_data(0, 32'h7F000000); step();
    req_valid = '0;
    step();
    chk("stat_conv4", stat_conv, 32'd4);
    chk("stat_ovf1", stat_ovf, 32'd1);
    $display("stats conv=%0d ovf=%0d", stat_conv, stat_ovf);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
